// File: rtl/ks16_prefix_pipe.sv
// ks16_prefix_pipe: pipelined 16-bit Kogge-Stone carry network with valid/ready and full-pipeline stall
module ks16_prefix_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p_out,
  output logic [15:0] c_out,
  output logic        cin_out
);
  logic [4:0]  v, ci;
  logic [15:0] p [5];
  logic [15:0] g [5];
  logic [15:0] pg [4];
  logic [15:0] gn [1:4];
  logic [15:0] pgn [1:3];
  logic        adv;
  assign adv = ~v[4] | out_ready;
  assign in_ready = adv;
  // Shifting by the span with zero fill leaves bits below the span untouched.
  for (genvar k = 1; k < 5; k++) begin : lvl
    localparam int d = 1 << (k - 1);
    assign gn[k] = g[k-1] | (pg[k-1] & {g[k-1][15-d:0], {d{1'b0}}});
    if (k < 4) begin : grp_p
      assign pgn[k] = pg[k-1] & {pg[k-1][15-d:0], {d{1'b1}}};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v  <= '0;
      ci <= '0;
      for (int i = 0; i < 5; i++) begin
        p[i] <= '0;
        g[i] <= '0;
      end
      for (int i = 0; i < 4; i++) pg[i] <= '0;
    end else if (adv) begin
      v     <= {v[3:0], in_valid};
      ci    <= {ci[3:0], cin};
      p[0]  <= a ^ b;
      pg[0] <= a ^ b;
      g[0]  <= {a[15:1] & b[15:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin)};
      for (int i = 1; i < 5; i++) begin
        p[i] <= p[i-1];
        g[i] <= gn[i];
      end
      for (int i = 1; i < 4; i++) pg[i] <= pgn[i];
    end
  end
  assign out_valid = v[4];
  assign p_out     = p[4];
  assign c_out     = g[4];
  assign cin_out   = ci[4];
endmodule

// File: tb/tb_ks16_prefix_pipe.sv
// tb_ks16_prefix_pipe: directed vector table streamed through the carry pipe plus stall and reset sequences
module tb_ks16_prefix_pipe;
  logic        clk = 1'b0, rst, in_valid, in_ready, cin, out_valid, out_ready, cin_out;
  logic [15:0] a, b, p_out, c_out;
  int          total = 0, bad = 0;
  typedef struct {
    logic [15:0] a, b;
    logic        cin;
    logic [15:0] p, c;
  } vec_t;
  vec_t tv[8];
  always #5 clk = ~clk;
  ks16_prefix_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .p_out(p_out), .c_out(c_out), .cin_out(cin_out)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic chk_out(input int i);
    logic [16:0] s, e;
    s = {c_out[15], p_out ^ {c_out[14:0], cin_out}};
    e = {1'b0, tv[i].a} + {1'b0, tv[i].b} + 17'(tv[i].cin);
    chk($sformatf("p_out[%0d]", i), p_out, tv[i].p);
    chk($sformatf("c_out[%0d]", i), c_out, tv[i].c);
    chk($sformatf("cin_out[%0d]", i), cin_out, tv[i].cin);
    chk($sformatf("sum[%0d]", i), s, e);
  endtask
  task automatic drive(input int i);
    a = tv[i].a;
    b = tv[i].b;
    cin = tv[i].cin;
  endtask
  task automatic stream(input int stall_at, input int stall_len, input bit chk_lat);
    int bi, oi, cyc;
    logic acc;
    logic [15:0] hp, hc;
    bi = 0;
    oi = 0;
    cyc = 0;
    hp = '0;
    hc = '0;
    while (oi < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid = bi < 8;
      drive(bi < 8 ? bi : 0);
      #1;
      if (chk_lat) chk($sformatf("valid_window@%0d", cyc), out_valid, cyc >= 5 && cyc < 13);
      if (!out_ready) begin
        chk($sformatf("in_ready_stall@%0d", cyc), in_ready, 0);
        chk($sformatf("valid_stall@%0d", cyc), out_valid, 1);
        if (cyc > stall_at) begin
          chk($sformatf("p_hold@%0d", cyc), p_out, hp);
          chk($sformatf("c_hold@%0d", cyc), c_out, hc);
        end
        hp = p_out;
        hc = c_out;
      end
      if (out_valid && out_ready) begin
        chk_out(oi);
        oi++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) bi++;
      cyc++;
    end
    chk("beats_out", oi, 8);
    @(negedge clk);
    in_valid = 0;
    out_ready = 1;
  endtask
  initial begin
    int n;
    logic seen;
    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFE, 16'hFFFF};
    tv[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5115, 16'h0221};
    tv[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF};
    tv[3] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
    tv[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF};
    tv[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 16'h8000};
    tv[7] = '{16'h00FF, 16'h0001, 1'b0, 16'h00FE, 16'h00FF};
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    drive(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_p_out", p_out, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_cin_out", cin_out, 0);
    stream(-10, 0, 1'b1);
    stream(7, 3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1;
      drive(i);
    end
    @(negedge clk);
    rst = 1;
    in_valid = 1;
    drive(5);
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_c_out", c_out, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    chk("no_stale_beat", seen, 0);
    @(negedge clk);
    in_valid = 1;
    drive(1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = 0;
      #1;
    end while (!out_valid && n < 20);
    chk("post_rst_latency", n, 5);
    chk_out(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
